conv_stream_sched: RTL

//   Frame scheduler for one streaming convolution layer. Accepts one frame of
//   IMG_W x IMG_H pixels and tracks the raster position of each pixel.

---
 rtl/conv_stream_sched.sv | 132 +++++++++++++
 1 files changed

// File: rtl/conv_stream_sched.sv
// Frame scheduler for a streaming KxK convolution layer: tracks raster
// position, flags window-completing pixels, drains the datapath, pulses done.
// Ports: clk, reset (async, high), start, in_valid -> in_ready, win_valid,
//   out_valid, col, row, busy, done.
module conv_stream_sched #(
  parameter int IMG_W    = 28,
  parameter int IMG_H    = 28,
  parameter int K        = 3,
  parameter int PIPE_LAT = 6,
  parameter int CNT_W    = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             win_valid,
  output logic             out_valid,
  output logic [CNT_W-1:0] col,
  output logic [CNT_W-1:0] row,
  output logic             busy,
  output logic             done
);

  localparam int DW = $clog2(PIPE_LAT + 1);

  localparam logic [CNT_W-1:0] COL_LAST = CNT_W'(IMG_W - 1);
  localparam logic [CNT_W-1:0] ROW_LAST = CNT_W'(IMG_H - 1);
  localparam logic [CNT_W:0]   KW       = (CNT_W + 1)'(K);
  localparam logic [DW-1:0]    DRN_LAST = DW'(PIPE_LAT - 1);

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    DRAIN,
    DONE
  } state_t;

  state_t state;
  state_t state_nxt;

  logic [DW-1:0]       drain_cnt;
  logic [PIPE_LAT-1:0] dly;
  logic                accept;
  logic                last_px;
  logic [CNT_W:0]      row_p1;
  logic [CNT_W:0]      col_p1;

  assign accept  = in_valid & in_ready;
  assign last_px = (row == ROW_LAST) & (col == COL_LAST);

  // Compare position+1 against K so K=1 needs no always-true test.
  assign row_p1 = {1'b0, row} + 1'b1;
  assign col_p1 = {1'b0, col} + 1'b1;

  assign win_valid = accept & (row_p1 >= KW) & (col_p1 >= KW);
  assign out_valid = dly[PIPE_LAT-1];

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    busy      = 1'b1;
    done      = 1'b0;
    unique case (state)
      IDLE: begin
        busy = 1'b0;
        if (start) state_nxt = LOAD;
      end
      LOAD: begin
        in_ready = 1'b1;
        if (accept && last_px) state_nxt = DRAIN;
      end
      DRAIN: begin
        if (drain_cnt == DRN_LAST) state_nxt = DONE;
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      row       <= '0;
      col       <= '0;
      drain_cnt <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            row <= '0;
            col <= '0;
          end
        end
        LOAD: begin
          if (accept) begin
            if (col == COL_LAST) begin
              col <= '0;
              // The last pixel leaves row at 0 rather than one past the frame.
              row <= last_px ? '0 : row + 1'b1;
            end else begin
              col <= col + 1'b1;
            end
            if (last_px) drain_cnt <= '0;
          end
        end
        DRAIN: drain_cnt <= drain_cnt + 1'b1;
        default: ;
      endcase
    end
  end

  if (PIPE_LAT == 1) begin : g_dly1
    always_ff @(posedge clk or posedge reset) begin
      if (reset) dly <= '0;
      else       dly <= win_valid;
    end
  end else begin : g_dlyn
    always_ff @(posedge clk or posedge reset) begin
      if (reset) dly <= '0;
      else       dly <= {dly[PIPE_LAT-2:0], win_valid};
    end
  end

endmodule
